param_subword_assembler: RTL

- Write-side counterpart of the bit-serial read-index logic in the Nibbler datapath.
- Accepts P_NBITS-wide subwords from the serial datapath and deposits each into a P_NBITS*P_NWORDS-bit word at a moving index, either LSB-first or MSB-first.
- Presents the completed word with a valid/ready handshake.
- Used for writeback of serially computed results, such as the ALU result or a load-data merge, into a full-width register.

---
 rtl/param_subword_assembler_if.sv | 33 +++
 rtl/param_subword_assembler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/param_subword_assembler_if.sv
// Subword-in / word-out handshake bundle for the subword assembler.
// The slave modport is the assembler's view; master is the datapath/consumer view.
interface param_subword_assembler_if #(
  parameter int P_NBITS  = 4,
  parameter int P_NWORDS = 8
);
  localparam int W = P_NBITS * P_NWORDS;

  logic               in_val;
  logic               in_rdy;
  logic [P_NBITS-1:0] in_data;
  logic               out_val;
  logic               out_rdy;
  logic [W-1:0]       out_data;

  modport slave (
    input  in_val,
    input  in_data,
    input  out_rdy,
    output in_rdy,
    output out_val,
    output out_data
  );

  modport master (
    output in_val,
    output in_data,
    output out_rdy,
    input  in_rdy,
    input  out_val,
    input  out_data
  );
endinterface

// File: rtl/param_subword_assembler.sv
// Deposits serial subwords into a full word at a moving index (LSB- or MSB-first)
// and hands the completed word to a consumer over a valid/ready handshake.
module param_subword_assembler #(
  parameter int P_NBITS   = 4,
  parameter int P_NWORDS  = 8,
  parameter int P_IDXBITS = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        direction,
  param_subword_assembler_if.slave    bus,
  output logic [P_IDXBITS-1:0]        idx,
  output logic                        busy
);
  localparam int W = P_NBITS * P_NWORDS;
  localparam logic [P_IDXBITS-1:0] IDX_LAST = P_IDXBITS'(P_NWORDS - 1);
  localparam logic [P_IDXBITS-1:0] IDX_ONE  = P_IDXBITS'(1);
  localparam logic [P_IDXBITS:0]   CNT_LAST = (P_IDXBITS + 1)'(P_NWORDS - 1);
  localparam logic [P_IDXBITS:0]   CNT_ONE  = (P_IDXBITS + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic                 dir_r, dir_s;
  logic [P_IDXBITS-1:0] idx_r, idx_s;
  logic [P_IDXBITS:0]   cnt_r, cnt_s;
  logic [W-1:0]         word_r, word_s;
  logic                 in_rdy_r, in_rdy_s;
  logic                 out_val_r, out_val_s;
  logic                 busy_r, busy_s;

  // State, datapath and output registers; reset discards any assembly in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      dir_r     <= 1'b1;
      idx_r     <= '0;
      cnt_r     <= '0;
      word_r    <= '0;
      in_rdy_r  <= 1'b0;
      out_val_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      dir_r     <= dir_s;
      idx_r     <= idx_s;
      cnt_r     <= cnt_s;
      word_r    <= word_s;
      in_rdy_r  <= in_rdy_s;
      out_val_r <= out_val_s;
      busy_r    <= busy_s;
    end
  end

  // Next-state and datapath update; start re-initialises from IDLE, FILL, or a completing DONE
  always_comb begin
    state_s = state_r;
    dir_s   = dir_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    word_s  = word_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_FILL;
          dir_s   = direction;
          idx_s   = direction ? '0 : IDX_LAST;
          cnt_s   = '0;
          word_s  = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (start) begin
          // abort: a beat offered in this cycle is dropped
          state_s = ST_FILL;
          dir_s   = direction;
          idx_s   = direction ? '0 : IDX_LAST;
          cnt_s   = '0;
          word_s  = '0;
        end else if (bus.in_val && in_rdy_r) begin
          word_s[int'(idx_r) * P_NBITS +: P_NBITS] = bus.in_data;
          idx_s = dir_r ? (idx_r + IDX_ONE) : (idx_r - IDX_ONE);
          cnt_s = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_FILL;
          end
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_DONE: begin
        if (bus.out_rdy) begin
          if (start) begin
            state_s = ST_FILL;
            dir_s   = direction;
            idx_s   = direction ? '0 : IDX_LAST;
            cnt_s   = '0;
            word_s  = '0;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state so the handshake flags come straight from flops
  always_comb begin
    in_rdy_s  = 1'b0;
    out_val_s = 1'b0;
    busy_s    = 1'b0;
    case (state_s)
      ST_IDLE: begin
        in_rdy_s  = 1'b0;
        out_val_s = 1'b0;
        busy_s    = 1'b0;
      end
      ST_FILL: begin
        in_rdy_s  = 1'b1;
        out_val_s = 1'b0;
        busy_s    = 1'b1;
      end
      ST_DONE: begin
        in_rdy_s  = 1'b0;
        out_val_s = 1'b1;
        busy_s    = 1'b1;
      end
      default: begin
        in_rdy_s  = 1'b0;
        out_val_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  assign bus.in_rdy   = in_rdy_r;
  assign bus.out_val  = out_val_r;
  assign bus.out_data = word_r;
  assign idx          = idx_r;
  assign busy         = busy_r;
endmodule
